acc_narrow_sat: RTL and testbench
=================================

Name: acc_narrow_sat

Overview:
- Return path of the sign-extending input delay line: takes wide signed accumulator results (48-bit DSP cascade output) and narrows them to the 18-bit sample format for the next beamformer stage.
- Operations: round, arithmetic right shift, saturate.
- Elastic 3-stage pipeline with valid/ready on both sides; no sample is dropped under backpressure.

Parameters:
- IN_WIDTH, 48: accumulator input width, signed.
- OUT_WIDTH, 18: output sample width, signed.
- SHIFT, 16: arithmetic right-shift applied before saturation. Legal range 0..IN_WIDTH-OUT_WIDTH.
- CNT_WIDTH, 16: saturation event counter width (optional feature only).

Ports:
- clk, in, 1: clock.
- rstn, in, 1: reset, asynchronous, active-low.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: block can accept a sample this cycle.
- in_data, in, IN_WIDTH: signed accumulator value.
- out_valid, out, 1: output sample valid.
- out_ready, in, 1: downstream accepts the sample this cycle.
- out_data, out, OUT_WIDTH: signed narrowed sample.
- out_sat, out, 1: out_data was clipped; qualified by out_valid.
- sat_clr, in, 1: synchronous clear of status (SAT_STATUS_EN only).
- sat_sticky, out, 1: any saturation since reset or clear (SAT_STATUS_EN only).
- sat_count, out, CNT_WIDTH: saturation event count (SAT_STATUS_EN only).

Behaviour:
- Reset (async assert, sync release): all stage valids = 0, data registers = 0.
  - Outputs during reset: out_valid=0, out_data=0, out_sat=0, sat_sticky=0, sat_count=0.
  - in_ready=1 as soon as rstn is high.
- Transfer rules:
  - A transfer occurs on a clock edge where valid && ready.
  - in_data is sampled only on input transfer.
  - out_data and out_sat must be held stable while out_valid && !out_ready.
- Stage S1 (round):
  - r = sext(in_data, IN_WIDTH+1) + (SHIFT>0 ? 2^(SHIFT-1) : 0).
  - Round half toward +infinity.
  - The extra bit prevents overflow at the most positive input.
- Stage S2 (shift):
  - q = r >>> SHIFT (arithmetic), width IN_WIDTH+1-SHIFT.
- Stage S3 (saturate):
  - q > 2^(OUT_WIDTH-1)-1: out_data = 0x1FFFF (default widths), out_sat = 1.
  - q < -2^(OUT_WIDTH-1): out_data = 0x20000, out_sat = 1.
  - Otherwise out_data = q[OUT_WIDTH-1:0], out_sat = 0.
- Pipeline control:
  - Each stage k has valid bit vk and ready rk = !vk || r(k+1), with r4 = out_ready.
  - in_ready = r1.
  - A stage loads when rk is high. Its valid takes the upstream valid, so bubbles collapse.
  - The ready chain is combinational across stages; no combinational path from in_valid to in_ready.
- Latency and throughput:
  - Exactly 3 cycles from input transfer to out_valid when out_ready is held 1.
  - 1 sample/cycle throughput.
  - Up to 3 samples held during a stall.
- Stall with full pipe: in_ready=0 the same cycle out_ready=0 (all three valids set).
  - When out_ready rises, in_ready rises combinationally in that cycle.
- Ordering: samples leave in input order; no duplication, no loss.
- Reset mid-stream: all in-flight samples are discarded. First output after release is the first sample accepted after release.

Optional Feature:
- Macro: ACC_NARROW_SAT_STATUS_EN.
- Defined:
  - sat_sticky sets on any output transfer with out_sat=1.
  - sat_count increments by 1 per such transfer and saturates at all-ones; it does not wrap.
  - sat_clr zeroes both. If clear and event occur in the same cycle, clear wins and the event is lost.
- Undefined:
  - Ports sat_clr, sat_sticky and sat_count are absent; no status logic.
  - Datapath and out_sat are unchanged.

Decomposition:
- Shared package (beamformer DSP package):
  - Sample width 18 and accumulator width 48 constants.
  - Signed max/min sample constants.
  - Typedefs sample_t and acc_t.
- One natural sub-module, valid_pipe_stage:
  - Single elastic register: valid bit, data register, ready = !v || ready_next.
  - Parameterised by data width; instanced three times.

Test Plan:
- Rounding: in=98304 (1.5×2^16) → out_data=2, out_sat=0. in=-98304 → -1. in=-32768 (-0.5) → 0. in=32767 → 0.
- Saturation: in=2^40 → out_data=131071, out_sat=1. in=-2^40 → -131072, out_sat=1. in=0x7FFF_FFFF_FFFF → 131071, no internal overflow.
- Latency/throughput: out_ready=1, in_valid=1 for 100 cycles with ramp 0..99×2^16 → first out_valid 3 cycles after the first accept; outputs 0..99 on consecutive cycles.
- Backpressure:
  - Streaming input, out_ready=0 for 6 cycles → in_ready drops after 3 accepts.
  - out_data holds stable during the stall.
  - After release, all samples arrive in order; random out_ready/in_valid over 10k samples match a reference model.
- Reset mid-stream: assert rstn low with 3 samples in flight → out_valid=0 immediately. After release, only newly accepted samples appear.
- Status (ACC_NARROW_SAT_STATUS_EN): 5 saturating plus 3 normal samples → sat_count=5, sat_sticky=1. sat_clr coinciding with a 6th saturating transfer → count=0, sticky=0. Force count to all-ones then saturate again → count holds at all-ones.

Source files
------------

// File: rtl/acc_narrow_sat_pkg.sv
// -----------------------------------------------------------------------------
// acc_narrow_sat_pkg
// Shared beamformer DSP constants and types: the 48-bit accumulator format
// coming out of the DSP cascade and the 18-bit sample format consumed by the
// next beamformer stage.
// No ports (package).
// -----------------------------------------------------------------------------
package acc_narrow_sat_pkg;

    localparam int ACC_W    = 48;
    localparam int SAMPLE_W = 18;

    typedef logic signed [ACC_W-1:0]    acc_t;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Signed sample extremes, used as the clip values.
    localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

endpackage : acc_narrow_sat_pkg

// File: rtl/acc_narrow_sat_valid_pipe_stage.sv
// -----------------------------------------------------------------------------
// acc_narrow_sat_valid_pipe_stage
// One elastic pipeline register (valid_pipe_stage): a valid bit plus a data
// register. The stage loads whenever it is empty or its content leaves this
// cycle, so bubbles collapse and one item per cycle flows at full rate.
//
// Handshake: an item moves across an interface on a rising clk edge where
// valid && ready. Data is only captured on an upstream transfer; ready is
// combinational from the downstream ready and never depends on up_valid_i.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   up_valid_i       upstream item valid
//   up_ready_o       stage can take an item this cycle (!valid || dn_ready_i)
//   up_data_i [W]    upstream item
//   dn_valid_o       stage holds an item
//   dn_ready_i       downstream takes the item this cycle
//   dn_data_o [W]    held item
// -----------------------------------------------------------------------------
module acc_narrow_sat_valid_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         up_valid_i,
    output logic         up_ready_o,
    input  logic [W-1:0] up_data_i,
    output logic         dn_valid_o,
    input  logic         dn_ready_i,
    output logic [W-1:0] dn_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign up_ready_o = !valid_q || dn_ready_i;
    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (up_ready_o) begin
            valid_q <= up_valid_i;
            if (up_valid_i) begin
                data_q <= up_data_i;
            end
        end
    end

endmodule : acc_narrow_sat_valid_pipe_stage

// File: rtl/acc_narrow_sat.sv
// -----------------------------------------------------------------------------
// acc_narrow_sat
// Narrows wide signed accumulator results to the signed sample format:
//   S1 round  : r = sext(in_data) + 2^(SHIFT-1)   (round half toward +inf)
//   S2 shift  : q = r >>> SHIFT
//   S3 clip   : saturate q to OUT_WIDTH bits, flag out_sat when clipped
// Three elastic stages, valid/ready on both sides, latency 3, 1 sample/cycle.
//
// Optional status (macro ACC_NARROW_SAT_STATUS_EN): sticky saturation flag and
// a saturating event counter, both cleared by sat_clr (clear beats an event).
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake
//   in_data  [IN_WIDTH]    signed accumulator value
//   out_valid / out_ready  output handshake
//   out_data [OUT_WIDTH]   signed narrowed sample
//   out_sat                out_data was clipped (qualified by out_valid)
//   sat_clr                clear status            (status build only)
//   sat_sticky             any saturation seen     (status build only)
//   sat_count [CNT_WIDTH]  saturation event count  (status build only)
// -----------------------------------------------------------------------------
module acc_narrow_sat
    import acc_narrow_sat_pkg::*;
#(
    parameter int IN_WIDTH  = ACC_W,
    parameter int OUT_WIDTH = SAMPLE_W,
    parameter int SHIFT     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
`ifdef ACC_NARROW_SAT_STATUS_EN
    input  logic                 sat_clr,
    output logic                 sat_sticky,
    output logic [CNT_WIDTH-1:0] sat_count,
`endif
    output logic                 out_sat
);

    localparam int RW = IN_WIDTH + 1;          // rounded value, one guard bit
    localparam int QW = IN_WIDTH + 1 - SHIFT;  // shifted value, always > OUT_WIDTH
    localparam int PW = OUT_WIDTH + 1;         // {sat, sample}

    // Half an output LSB; written as (1<<SHIFT)>>1 so SHIFT=0 gives 0.
    localparam logic [RW-1:0] RND = (RW'(1) << SHIFT) >> 1;

    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic          s1_valid, s1_ready, s2_valid, s2_ready, s3_ready;
    logic [RW-1:0] s1_d, s1_q;
    logic [QW-1:0] s2_d, s2_q;
    logic [PW-1:0] s3_d, s3_q;

    logic                 sat_d;
    logic [OUT_WIDTH-1:0] narrow_d;

    // S1: sign-extend by one bit so the most positive input cannot overflow.
    assign s1_d = {in_data[IN_WIDTH-1], in_data} + RND;

    // S2: arithmetic shift; the dropped top bits are pure sign copies.
    assign s2_d = QW'($signed(s1_q) >>> SHIFT);

    // S3: q fits when every bit from the output sign bit upward matches.
    always_comb begin
        sat_d    = 1'b0;
        narrow_d = s2_q[OUT_WIDTH-1:0];
        if (s2_q[QW-1:OUT_WIDTH-1] != {(QW-OUT_WIDTH+1){s2_q[QW-1]}}) begin
            sat_d    = 1'b1;
            narrow_d = s2_q[QW-1] ? OUT_MIN : OUT_MAX;
        end
    end

    assign s3_d = {sat_d, narrow_d};

    acc_narrow_sat_valid_pipe_stage #(.W(RW)) u_s1_round (
        .clk        (clk),
        .rstn       (rstn),
        .up_valid_i (in_valid),
        .up_ready_o (in_ready),
        .up_data_i  (s1_d),
        .dn_valid_o (s1_valid),
        .dn_ready_i (s1_ready),
        .dn_data_o  (s1_q)
    );

    acc_narrow_sat_valid_pipe_stage #(.W(QW)) u_s2_shift (
        .clk        (clk),
        .rstn       (rstn),
        .up_valid_i (s1_valid),
        .up_ready_o (s1_ready),
        .up_data_i  (s2_d),
        .dn_valid_o (s2_valid),
        .dn_ready_i (s2_ready),
        .dn_data_o  (s2_q)
    );

    acc_narrow_sat_valid_pipe_stage #(.W(PW)) u_s3_sat (
        .clk        (clk),
        .rstn       (rstn),
        .up_valid_i (s2_valid),
        .up_ready_o (s2_ready),
        .up_data_i  (s3_d),
        .dn_valid_o (out_valid),
        .dn_ready_i (s3_ready),
        .dn_data_o  (s3_q)
    );

    assign s3_ready = out_ready;
    assign out_sat  = s3_q[OUT_WIDTH];
    assign out_data = s3_q[OUT_WIDTH-1:0];

`ifdef ACC_NARROW_SAT_STATUS_EN
    logic                 sticky_q;
    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else if (sat_clr) begin
            // A clear in the same cycle as an event drops the event.
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else if (out_valid && out_ready && out_sat) begin
            sticky_q <= 1'b1;
            if (count_q != '1) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign sat_sticky = sticky_q;
    assign sat_count  = count_q;
`endif

endmodule : acc_narrow_sat

// File: tb/tb_acc_narrow_sat.sv
// -----------------------------------------------------------------------------
// tb_acc_narrow_sat
// Directed and randomized checks of acc_narrow_sat at default widths
// (48 -> 18, shift 16). Status checks are compiled in when
// ACC_NARROW_SAT_STATUS_EN is defined.
// -----------------------------------------------------------------------------
module tb_acc_narrow_sat;

    localparam int IW = 48;
    localparam int OW = 18;
    localparam int SH = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_sat;
`ifdef ACC_NARROW_SAT_STATUS_EN
    logic          sat_clr = 1'b0;
    logic          sat_sticky;
    logic [CW-1:0] sat_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [OW:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    acc_narrow_sat #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .SHIFT     (SH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef ACC_NARROW_SAT_STATUS_EN
        .sat_clr    (sat_clr),
        .sat_sticky (sat_sticky),
        .sat_count  (sat_count),
`endif
        .out_sat    (out_sat)
    );

    // Reference: round half up, shift by 16, clip to 18 bits. Returns {sat, data}.
    function automatic logic [OW:0] ref_narrow(input longint x);
        longint q;
        q = (x + 64'sd32768) >>> 16;
        if (q > 64'sd131071)  return {1'b1, 18'h1FFFF};
        if (q < -64'sd131072) return {1'b1, 18'h20000};
        return {1'b0, q[17:0]};
    endfunction

    // ---------------- driver tasks ----------------
    // Sends one sample into an empty pipe and returns the output once visible.
    task automatic send_and_get(input longint x, output logic [OW:0] got, output bit ok);
        ok  = 1'b0;
        got = '0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = x[IW-1:0];
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid === 1'b1) begin
                got = {out_sat, out_data};
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b data=%h sat=%b, want 0/0/0", out_valid, out_data, out_sat);
        end
`ifdef ACC_NARROW_SAT_STATUS_EN
        n_cmp++;
        if (sat_sticky !== 1'b0 || sat_count !== '0) begin
            n_err++;
            $display("FAIL reset_status: got sticky=%b count=%0d, want 0/0", sat_sticky, sat_count);
        end
`endif
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_rounding_saturation();
        longint      vec[14];
        logic [OW:0] exp_v[14];
        logic [OW:0] got;
        bit          ok;
        vec = '{64'sd98304, -64'sd98304, -64'sd32768, 64'sd32767,
                64'sd1099511627776, -64'sd1099511627776, 64'sh7FFF_FFFF_FFFF,
                -64'sd140737488355328,
                64'sd8589869056, 64'sd8589901823, 64'sd8589901824,
                -64'sd8589934592, -64'sd8589967360, -64'sd8589967361};
        exp_v = '{19'h00002, 19'h3FFFF, 19'h00000, 19'h00000,
                  19'h5FFFF, 19'h60000, 19'h5FFFF,
                  19'h60000,
                  19'h1FFFF, 19'h1FFFF, 19'h5FFFF,
                  19'h20000, 19'h20000, 19'h60000};
        for (int i = 0; i < 14; i++) begin
            send_and_get(vec[i], got, ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL narrow_%0d: no output within 8 cycles, want sat=%b data=%h", i, exp_v[i][OW], exp_v[i][OW-1:0]);
            end else if (got !== exp_v[i]) begin
                n_err++;
                $display("FAIL narrow_%0d: in=%0d got sat=%b data=%h, want sat=%b data=%h",
                         i, vec[i], got[OW], got[OW-1:0], exp_v[i][OW], exp_v[i][OW-1:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_latency_throughput();
        logic    want_v;
        logic [OW-1:0] want_d;
        longint  x;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 105; cyc++) begin
            @(negedge clk);
            want_v = (cyc >= 3 && cyc < 103);
            want_d = OW'(cyc - 3);
            n_cmp++;
            if (out_valid !== want_v) begin
                n_err++;
                $display("FAIL ramp_valid cyc %0d: got %b want %b", cyc, out_valid, want_v);
            end else if (want_v && (out_data !== want_d || out_sat !== 1'b0)) begin
                n_err++;
                $display("FAIL ramp_data cyc %0d: got %0d sat=%b want %0d sat=0", cyc, out_data, out_sat, want_d);
            end
            in_valid = (cyc < 100);
            x        = longint'(cyc) <<< 16;
            in_data  = x[IW-1:0];
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL ramp_in_ready cyc %0d: got %b want 1", cyc, in_ready);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int          next = 1000;
        int          accepted = 0;
        int          sent = 0;
        int          got_n = 0;
        logic [OW-1:0] hold_d = '0;
        bit          have_hold = 1'b0;
        longint      x;
        logic [OW:0] e;
        exp_q.delete();
        // Stall phase: downstream refuses for 6 cycles.
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            x         = longint'(next) <<< 16;
            in_data   = x[IW-1:0];
            #1;
            n_cmp++;
            if (in_ready !== (cyc < 3)) begin
                n_err++;
                $display("FAIL stall_in_ready cyc %0d: got %b want %b", cyc, in_ready, (cyc < 3));
            end
            if (out_valid === 1'b1) begin
                if (!have_hold) begin
                    hold_d    = out_data;
                    have_hold = 1'b1;
                end else begin
                    n_cmp++;
                    if (out_data !== hold_d) begin
                        n_err++;
                        $display("FAIL stall_hold cyc %0d: got %0d want %0d", cyc, out_data, hold_d);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, OW'(next)});
                next++;
                accepted++;
            end
        end
        n_cmp++;
        if (accepted != 3 || !have_hold) begin
            n_err++;
            $display("FAIL stall_accepts: got %0d accepts (out_valid seen=%b), want 3 (1)", accepted, have_hold);
        end
        // Release: in_ready must follow out_ready in the same cycle.
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (sent < 4);
            x         = longint'(next) <<< 16;
            in_data   = x[IW-1:0];
            #1;
            if (cyc == 0) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL release_in_ready: got %b want 1", in_ready);
                end
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                got_n++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL release_order: unexpected output %0d, want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_sat, out_data} !== e) begin
                        n_err++;
                        $display("FAIL release_order: got %0d sat=%b want %0d sat=%b", out_data, out_sat, e[OW-1:0], e[OW]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, OW'(next)});
                next++;
                sent++;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got_n != 7 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL release_count: got %0d outputs (%0d left), want 7 (0)", got_n, exp_q.size());
        end
    endtask

    task automatic test_random();
        localparam int N = 10000;
        int          sent = 0;
        int          recv = 0;
        int          cycles = 0;
        longint      cur;
        logic [OW:0] prev = '0;
        logic [OW:0] e;
        bit          prev_stall = 1'b0;
        exp_q.delete();
        cur = longint'({$urandom, $urandom}) >>> $urandom_range(16, 47);
        while (recv < N && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
            in_data   = cur[IW-1:0];
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || {out_sat, out_data} !== prev) begin
                    n_err++;
                    $display("FAIL rand_hold: got valid=%b sat=%b data=%h want 1/%b/%h",
                             out_valid, out_sat, out_data, prev[OW], prev[OW-1:0]);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                recv++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_data: unexpected output %h, want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_sat, out_data} !== e) begin
                        n_err++;
                        $display("FAIL rand_data #%0d: got sat=%b data=%h want sat=%b data=%h",
                                 recv, out_sat, out_data, e[OW], e[OW-1:0]);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(ref_narrow(cur));
                sent++;
                cur = longint'({$urandom, $urandom}) >>> $urandom_range(16, 47);
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev       = {out_sat, out_data};
        end
        in_valid = 1'b0;
        n_cmp++;
        if (recv != N || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_complete: got %0d outputs (%0d pending), want %0d (0)", recv, exp_q.size(), N);
        end
    endtask

    task automatic test_reset_midstream();
        longint      x;
        logic [OW:0] e;
        int          got_n = 0;
        exp_q.delete();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x        = longint'(7 + i) <<< 16;
            in_data  = x[IW-1:0];
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_prefill: got out_valid=%b want 1", out_valid);
        end
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            n_err++;
            $display("FAIL midreset_flush: got valid=%b data=%0d want 0/0", out_valid, out_data);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        exp_q.push_back({1'b0, 18'd55});
        exp_q.push_back({1'b0, 18'd66});
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (cyc < 2);
            x         = (cyc == 0) ? (longint'(55) <<< 16) : (longint'(66) <<< 16);
            in_data   = x[IW-1:0];
            #1;
            if (out_valid === 1'b1) begin
                n_cmp++;
                got_n++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL midreset_after: unexpected output %0d, want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_sat, out_data} !== e) begin
                        n_err++;
                        $display("FAIL midreset_after: got %0d want %0d", out_data, e[OW-1:0]);
                    end
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got_n != 2) begin
            n_err++;
            $display("FAIL midreset_count: got %0d outputs want 2", got_n);
        end
    endtask

`ifdef ACC_NARROW_SAT_STATUS_EN
    task automatic test_status();
        logic [OW:0] got;
        bit          ok;
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        n_cmp++;
        if (sat_sticky !== 1'b0 || sat_count !== '0) begin
            n_err++;
            $display("FAIL status_clear: got sticky=%b count=%0d want 0/0", sat_sticky, sat_count);
        end
        for (int i = 0; i < 8; i++) begin
            send_and_get((i < 5) ? 64'sd1099511627776 : (longint'(i) <<< 16), got, ok);
        end
        @(negedge clk);
        n_cmp++;
        if (sat_sticky !== 1'b1 || sat_count !== 4'd5) begin
            n_err++;
            $display("FAIL status_count5: got sticky=%b count=%0d want 1/5", sat_sticky, sat_count);
        end
        // Clear coinciding with a saturating transfer: clear wins.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 48'h0100_0000_0000;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8 && out_valid !== 1'b1; k++) @(negedge clk);
        out_ready = 1'b1;
        sat_clr   = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        n_cmp++;
        if (sat_sticky !== 1'b0 || sat_count !== '0) begin
            n_err++;
            $display("FAIL status_clr_wins: got sticky=%b count=%0d want 0/0", sat_sticky, sat_count);
        end
        for (int i = 0; i < 20; i++) send_and_get(-64'sd1099511627776, got, ok);
        @(negedge clk);
        n_cmp++;
        if (sat_count !== 4'hF) begin
            n_err++;
            $display("FAIL status_cap: got count=%0d want 15", sat_count);
        end
        send_and_get(64'sd1099511627776, got, ok);
        @(negedge clk);
        n_cmp++;
        if (sat_count !== 4'hF || sat_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL status_nowrap: got count=%0d sticky=%b want 15/1", sat_count, sat_sticky);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_rounding_saturation();
        test_latency_throughput();
        test_backpressure();
        test_random();
        test_reset_midstream();
`ifdef ACC_NARROW_SAT_STATUS_EN
        test_status();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_acc_narrow_sat
